// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with Hi/Lo result pair and start/done handshake.
// Optional MULTDIV_ZERO_SKIP_EN: zero operands finish in one cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] amag, bmag;
    logic [WIDTH:0]   upper_ext, mcand_ext, booth_sum;
    logic [PW-1:0]    booth_next, shifted, div_next;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             skip;

    assign amag = A[WIDTH-1] ? -A : A;
    assign bmag = B[WIDTH-1] ? -B : B;

    // Booth accumulator carries a guard bit so subtracting the most-negative
    // multiplicand cannot overflow before the arithmetic shift.
    assign upper_ext = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
    assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        booth_sum = upper_ext;
        unique case (prod_q[1:0])
            2'b01:   booth_sum = upper_ext + mcand_ext;
            2'b10:   booth_sum = upper_ext - mcand_ext;
            default: booth_sum = upper_ext;
        endcase
    end

    assign booth_next = {booth_sum, prod_q[WIDTH:1]};

    // Division layout: {remainder[WIDTH:0], dividend/quotient[WIDTH-1:0]}.
    assign shifted  = {prod_q[PW-2:0], 1'b0};
    assign trial    = shifted[PW-1:WIDTH] - {1'b0, mcand_q};
    assign div_next = trial[WIDTH] ? shifted
                                   : {trial, shifted[WIDTH-1:1], 1'b1};

    assign quo_fix = negq_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_fix = negr_q ? -prod_q[PW-2:WIDTH] : prod_q[PW-2:WIDTH];

`ifdef MULTDIV_ZERO_SKIP_EN
    assign skip = Op ? (A == '0) : ((A == '0) || (B == '0));
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    dz_d  = 1'b0;
                    cnt_d = '0;
                    if (Op && (B == '0)) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (skip) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = S_DONE;
                    end else if (!Op) begin
                        mcand_d = A;
                        prod_d  = {{WIDTH{1'b0}}, B, 1'b0};
                        state_d = S_MULT;
                    end else begin
                        mcand_d = bmag;
                        prod_d  = {{(WIDTH+1){1'b0}}, amag};
                        negq_d  = A[WIDTH-1] ^ B[WIDTH-1];
                        negr_d  = A[WIDTH-1];
                        state_d = S_DIV;
                    end
                end
            end
            S_MULT: begin
                prod_d = booth_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = booth_next[PW-1:WIDTH+1];
                    lo_d    = booth_next[WIDTH:1];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = rem_fix;
                lo_d    = quo_fix;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign Done    = (state_q == S_DONE);
    assign DivZero = dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

    logic        Clk, Reset, Start, Op;
    logic [31:0] A, B, Hi, Lo;
    logic        Busy, Done, DivZero;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for Busy low, then presents a request sampled by the next edge
    // (edge 0). Returns at #1 after edge 0.
    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        for (int i = 0; i < 100 && Busy; i++) @(negedge Clk);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    // lat = number of the first edge that samples Done=1, counting from the
    // current position as edge 0; -1 on timeout.
    task automatic wait_done(output int lat, output bit busy_ok);
        bit found;
        lat = -1; busy_ok = 1'b1; found = 1'b0;
        for (int e = 0; e < 100 && !found; e++) begin
            if (!Busy) busy_ok = 1'b0;
            if (Done) begin
                lat = e + 1;
                found = 1'b1;
            end else begin
                @(posedge Clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b1; Op = 1'b0; A = 32'd3; B = 32'd4;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", DivZero); end
        checks++; if (Hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", Hi); end
        checks++; if (Lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", Lo); end
        Reset = 1'b0; Start = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_mult_basic;
        int lat; bit bok;
        start_op(1'b0, 32'hFFFFFFFF, 32'd7);
        wait_done(lat, bok);
        checks++; if (lat != 33) begin failures++; $display("FAIL mul_lat got=%0d exp=33", lat); end
        checks++; if (!bok) begin failures++; $display("FAIL mul_busy got=low exp=high_edges_1_33"); end
        checks++; if (Hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mul_m1x7_hi got=%h exp=ffffffff", Hi); end
        checks++; if (Lo !== 32'hFFFFFFF9) begin failures++; $display("FAIL mul_m1x7_lo got=%h exp=fffffff9", Lo); end
        @(posedge Clk);
        #1;
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", Done); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mul_busy_after got=%b exp=0", Busy); end
    endtask

    task automatic test_mult_minneg_then_div;
        int lat; bit bok;
        start_op(1'b0, 32'h80000000, 32'h80000000);
        wait_done(lat, bok);
        checks++; if (lat != 33) begin failures++; $display("FAIL mul_min_lat got=%0d exp=33", lat); end
        checks++; if (Hi !== 32'h40000000) begin failures++; $display("FAIL mul_min_hi got=%h exp=40000000", Hi); end
        checks++; if (Lo !== 32'h0) begin failures++; $display("FAIL mul_min_lo got=%h exp=0", Lo); end
        start_op(1'b1, -32'sd7, 32'd2);
        wait_done(lat, bok);
        checks++; if (lat != 34) begin failures++; $display("FAIL div_lat got=%0d exp=34", lat); end
        checks++; if (!bok) begin failures++; $display("FAIL div_busy got=low exp=high"); end
        checks++; if (Lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_m7d2_lo got=%h exp=fffffffd", Lo); end
        checks++; if (Hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_m7d2_hi got=%h exp=ffffffff", Hi); end
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL div_m7d2_dz got=%b exp=0", DivZero); end
    endtask

    task automatic test_div_signs;
        int lat; bit bok;
        start_op(1'b1, 32'd7, -32'sd2);
        wait_done(lat, bok);
        checks++; if (Lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_7dm2_lo got=%h exp=fffffffd", Lo); end
        checks++; if (Hi !== 32'h1) begin failures++; $display("FAIL div_7dm2_hi got=%h exp=1", Hi); end
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bok);
        checks++; if (Lo !== 32'h80000000) begin failures++; $display("FAIL div_minm1_lo got=%h exp=80000000", Lo); end
        checks++; if (Hi !== 32'h0) begin failures++; $display("FAIL div_minm1_hi got=%h exp=0", Hi); end
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL div_minm1_dz got=%b exp=0", DivZero); end
    endtask

    task automatic test_divzero;
        int lat; bit bok;
        start_op(1'b1, 32'h0ACF1234, 32'h2000);
        wait_done(lat, bok);
        checks++; if (Lo !== 32'h5678) begin failures++; $display("FAIL div_pre_lo got=%h exp=5678", Lo); end
        checks++; if (Hi !== 32'h1234) begin failures++; $display("FAIL div_pre_hi got=%h exp=1234", Hi); end
        start_op(1'b1, 32'd5, 32'd0);
        wait_done(lat, bok);
        checks++; if (lat != 1) begin failures++; $display("FAIL dz_lat got=%0d exp=1", lat); end
        checks++; if (DivZero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", DivZero); end
        checks++; if (Hi !== 32'h1234) begin failures++; $display("FAIL dz_hi_hold got=%h exp=1234", Hi); end
        checks++; if (Lo !== 32'h5678) begin failures++; $display("FAIL dz_lo_hold got=%h exp=5678", Lo); end
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (DivZero !== 1'b1) begin failures++; $display("FAIL dz_held got=%b exp=1", DivZero); end
        start_op(1'b0, 32'd2, 32'd3);
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL dz_clear got=%b exp=0", DivZero); end
        wait_done(lat, bok);
        checks++; if (Lo !== 32'd6) begin failures++; $display("FAIL dz_next_lo got=%h exp=6", Lo); end
    endtask

    task automatic test_start_while_busy;
        int lat; bit bok; bit seen;
        start_op(1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge Clk);
        #1;
        Start = 1'b1; Op = 1'b1; A = 32'd9; B = 32'd9;
        @(posedge Clk);
        #1;
        Start = 1'b0; A = 32'hDEADBEEF; B = 32'h0;
        wait_done(lat, bok);
        checks++; if (lat != 23) begin failures++; $display("FAIL busy_ign_lat got=%0d exp=23", lat); end
        checks++; if (Lo !== 32'd12) begin failures++; $display("FAIL busy_ign_lo got=%h exp=c", Lo); end
        checks++; if (Hi !== 32'd0) begin failures++; $display("FAIL busy_ign_hi got=%h exp=0", Hi); end
        @(posedge Clk);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1 if (Done || Busy) seen = 1'b1;
            @(posedge Clk);
        end
        #1;
        checks++; if (seen) begin failures++; $display("FAIL busy_ign_second got=active exp=idle"); end
    endtask

    task automatic test_reset_mid;
        int lat; bit bok; bit seen;
        start_op(1'b0, 32'd6, 32'd7);
        repeat (14) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", Busy); end
        checks++; if (Hi !== 32'h0 || Lo !== 32'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", Hi, Lo); end
        Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1 if (Done) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL rst_mid_done got=pulse exp=none"); end
        start_op(1'b0, 32'd6, 32'd7);
        wait_done(lat, bok);
        checks++; if (lat != 33) begin failures++; $display("FAIL rst_mid_relat got=%0d exp=33", lat); end
        checks++; if (Lo !== 32'd42) begin failures++; $display("FAIL rst_mid_lo got=%h exp=2a", Lo); end
    endtask

    task automatic test_zero_operand;
        int lat; bit bok; int exp_lat;
`ifdef MULTDIV_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 33;
`endif
        start_op(1'b0, 32'd0, 32'd123);
        wait_done(lat, bok);
        checks++; if (lat != exp_lat) begin failures++; $display("FAIL zero_lat got=%0d exp=%0d", lat, exp_lat); end
        checks++; if (Hi !== 32'h0 || Lo !== 32'h0) begin failures++; $display("FAIL zero_hilo got=%h_%h exp=0_0", Hi, Lo); end
        start_op(1'b1, 32'd0, 32'd5);
        wait_done(lat, bok);
        exp_lat = (exp_lat == 1) ? 1 : 34;
        checks++; if (lat != exp_lat) begin failures++; $display("FAIL zero_div_lat got=%0d exp=%0d", lat, exp_lat); end
        checks++; if (Hi !== 32'h0 || Lo !== 32'h0) begin failures++; $display("FAIL zero_div_hilo got=%h_%h exp=0_0", Hi, Lo); end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
        test_reset();
        test_mult_basic();
        test_mult_minneg_then_div();
        test_div_signs();
        test_divzero();
        test_start_while_busy();
        test_reset_mid();
        test_zero_operand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
